// File: rtl/rd_ptr_if.sv
// rtl/rd_ptr_if.sv - output stream, RAM read port and pointer exchange for rd_ptr
interface rd_ptr_if #(
    parameter int ALEN = 8,
    parameter int DLEN = 32
);
    logic            o_tvalid;
    logic            i_tready;
    logic [DLEN-1:0] o_tdata;
    logic [ALEN-1:0] o_raddr;
    logic [ALEN:0]   o_rptr;
    logic [ALEN:0]   i_wptr;
    logic            o_ram_ren;
    logic [DLEN-1:0] i_ram_rdata;

    modport master (
        output o_tvalid, o_tdata, o_raddr, o_rptr, o_ram_ren,
        input  i_tready, i_wptr, i_ram_rdata
    );

    modport slave (
        input  o_tvalid, o_tdata, o_raddr, o_rptr, o_ram_ren,
        output i_tready, i_wptr, i_ram_rdata
    );
endinterface

// File: rtl/rd_ptr.sv
// rtl/rd_ptr.sv - FIFO read pointer, empty detect, RAM read issue and 2-entry output buffer
module rd_ptr #(
    parameter int ALEN = 8,
    parameter int DLEN = 32,
    parameter int INCR = 1
) (
    input  logic     clk,
    input  logic     rstn,
    rd_ptr_if.master bus
);
    localparam int PW = ALEN + 1;
    localparam logic [PW-1:0] INCR_W = PW'(INCR);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    buf_state_t      state, state_d;
    logic [DLEN-1:0] head, head_d;
    logic [DLEN-1:0] skid, skid_d;
    logic [PW-1:0]   rptr;
    logic            rstn_q;
    logic            inflight;
    logic [1:0]      occ;
    logic            tvalid;
    logic            empty;
    logic            pop;
    logic            ren;
    logic [2:0]      pending;
    logic [2:0]      limit;

    assign occ     = state;
    assign tvalid  = (state != EMPTY);
    assign empty   = (rptr == bus.i_wptr);
    assign pop     = tvalid & bus.i_tready;
    assign pending = {1'b0, occ} + {2'b00, inflight};
    assign limit   = 3'd2 + {2'b00, pop};
    // Only issue a read if its word is guaranteed a slot once it lands.
    assign ren     = rstn & rstn_q & !empty & (pending < limit);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rstn_q   <= 1'b0;
            inflight <= 1'b0;
            rptr     <= '0;
            state    <= EMPTY;
            head     <= '0;
            skid     <= '0;
        end else begin
            rstn_q   <= 1'b1;
            inflight <= ren;
            if (ren) begin
                rptr <= rptr + INCR_W;
            end
            state <= state_d;
            head  <= head_d;
            skid  <= skid_d;
        end
    end

    always_comb begin
        state_d = state;
        head_d  = head;
        skid_d  = skid;
        case (state)
            EMPTY: begin
                if (inflight) begin
                    state_d = ONE;
                    head_d  = bus.i_ram_rdata;
                end
            end
            ONE: begin
                if (inflight && !pop) begin
                    state_d = TWO;
                    skid_d  = bus.i_ram_rdata;
                end else if (pop && !inflight) begin
                    state_d = EMPTY;
                end else if (pop && inflight) begin
                    head_d = bus.i_ram_rdata;
                end
            end
            TWO: begin
                if (pop) begin
                    head_d = skid;
                    if (inflight) begin
                        skid_d = bus.i_ram_rdata;
                    end else begin
                        state_d = ONE;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign bus.o_tvalid  = tvalid;
    assign bus.o_tdata   = head;
    assign bus.o_raddr   = rptr[ALEN-1:0];
    assign bus.o_rptr    = rptr;
    assign bus.o_ram_ren = ren;
endmodule

// File: tb/tb_rd_ptr.sv
// tb/tb_rd_ptr.sv - self-checking bench for rd_ptr with write-side, RAM and scoreboard models
module tb_rd_ptr;
    localparam int ALEN = 4;
    localparam int DLEN = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    rd_ptr_if #(.ALEN(ALEN), .DLEN(DLEN)) bus ();
    rd_ptr #(.ALEN(ALEN), .DLEN(DLEN), .INCR(1)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    logic [31:0] mem [16];
    logic [4:0]  wptr = 5'd0;
    logic        tready = 1'b0;
    logic [31:0] q [$];
    logic [4:0]  pops = 5'd0;
    logic [4:0]  outst;
    logic [4:0]  prev_rptr = 5'd0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    int          wraps = 0;
    int          nreads;
    int          checks = 0;
    int          errors = 0;

    assign bus.i_wptr   = wptr;
    assign bus.i_tready = tready;

    always @(posedge clk) begin
        if (bus.o_ram_ren) bus.i_ram_rdata <= mem[bus.o_raddr];
    end

    typedef struct {
        logic        wr;
        logic [31:0] wdata;
        logic        tready;
        logic        exp_ren;
        logic        exp_tvalid;
        logic [4:0]  exp_rptr;
        logic [31:0] exp_tdata;
    } vec_t;
    vec_t vt [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] d);
        mem[wptr[3:0]] = d;
        wptr = wptr + 5'd1;
        q.push_back(d);
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b0;
        wptr = 5'd0;
        q.delete();
        pops = 5'd0;
        prev_rptr = 5'd0;
        tready = 1'b0;
        repeat (n) begin
            tick();
            @(negedge clk);
            check("rst_tvalid", 64'(bus.o_tvalid), 64'd0);
            check("rst_rptr", 64'(bus.o_rptr), 64'd0);
            check("rst_raddr", 64'(bus.o_raddr), 64'd0);
            check("rst_ren", 64'(bus.o_ram_ren), 64'd0);
            check("rst_tdata", 64'(bus.o_tdata), 64'd0);
        end
        tick();
        rstn = 1'b1;
    endtask

    // Stream-level invariants and in-order scoreboard, every cycle out of reset.
    always @(negedge clk) begin
        if (rstn) begin
            check("raddr_eq_rptr", 64'(bus.o_raddr), 64'(bus.o_rptr[3:0]));
            outst = bus.o_rptr - pops;
            check("at_most_2_outstanding", 64'(outst <= 5'd2), 64'd1);
            check("no_read_past_write", 64'((wptr - bus.o_rptr) <= 5'd16), 64'd1);
            if (bus.o_rptr == wptr) check("no_read_when_empty", 64'(bus.o_ram_ren), 64'd0);
            check("no_fill_when_two", 64'(dut.occ == 2'd2 && dut.inflight && !(bus.o_tvalid && tready)), 64'd0);
            if (prev_stall) begin
                check("stall_valid_hold", 64'(bus.o_tvalid), 64'd1);
                check("stall_data_hold", 64'(bus.o_tdata), 64'(prev_data));
            end
            if (prev_rptr == 5'd31 && bus.o_rptr == 5'd0) wraps++;
            prev_rptr  = bus.o_rptr;
            prev_stall = bus.o_tvalid & !tready;
            prev_data  = bus.o_tdata;
            if (bus.o_tvalid && tready) begin
                check("sb_word_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) check("sb_order", 64'(bus.o_tdata), 64'(q.pop_front()));
                pops = pops + 5'd1;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        //         wr    wdata          trdy  ren   valid rptr   tdata
        vt[0]  = '{1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vt[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 5'd0, 32'h0};
        vt[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd1, 32'h0};
        vt[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd1, 32'hA5A5A5A5};
        vt[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd1, 32'h0};
        vt[5]  = '{1'b1, 32'h11,       1'b0, 1'b1, 1'b0, 5'd1, 32'h0};
        vt[6]  = '{1'b1, 32'h22,       1'b0, 1'b1, 1'b0, 5'd2, 32'h0};
        vt[7]  = '{1'b1, 32'h33,       1'b0, 1'b0, 1'b1, 5'd3, 32'h11};
        vt[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 5'd3, 32'h11};
        vt[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 5'd3, 32'h11};
        vt[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd4, 32'h22};
        vt[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd4, 32'h33};
        vt[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 5'd4, 32'h0};

        // Reset, single word, then a short stall/release sequence.
        do_reset(3);
        for (int i = 0; i < 13; i++) begin
            if (vt[i].wr) do_write(vt[i].wdata);
            tready = vt[i].tready;
            @(negedge clk);
            check($sformatf("vec%0d_ren", i), 64'(bus.o_ram_ren), 64'(vt[i].exp_ren));
            check($sformatf("vec%0d_tvalid", i), 64'(bus.o_tvalid), 64'(vt[i].exp_tvalid));
            check($sformatf("vec%0d_rptr", i), 64'(bus.o_rptr), 64'(vt[i].exp_rptr));
            if (vt[i].exp_tvalid) check($sformatf("vec%0d_tdata", i), 64'(bus.o_tdata), 64'(vt[i].exp_tdata));
            tick();
        end

        // Full FIFO (wptr=16, rptr=0) streamed out back to back.
        do_reset(3);
        for (int i = 0; i < 16; i++) do_write(32'h1000 + i);
        tready = 1'b1;
        @(negedge clk);
        check("stream_no_ren_after_reset", 64'(bus.o_ram_ren), 64'd0);
        tick();
        @(negedge clk);
        check("full_not_empty_ren", 64'(bus.o_ram_ren), 64'd1);
        check("stream_latency_v1", 64'(bus.o_tvalid), 64'd0);
        tick();
        @(negedge clk);
        check("stream_latency_v2", 64'(bus.o_tvalid), 64'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("stream_valid", 64'(bus.o_tvalid), 64'd1);
            check("stream_data", 64'(bus.o_tdata), 64'(32'h1000 + i));
            tick();
        end
        @(negedge clk);
        check("stream_end_valid", 64'(bus.o_tvalid), 64'd0);
        check("stream_end_rptr", 64'(bus.o_rptr), 64'd16);
        tick();

        // Backpressure: 8 words, consumer stalled for 10 cycles.
        do_reset(3);
        for (int i = 0; i < 8; i++) do_write(32'h2000 + i);
        tready = 1'b0;
        nreads = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_ram_ren) nreads++;
            tick();
        end
        @(negedge clk);
        check("bp_reads_issued", 64'(nreads), 64'd2);
        check("bp_rptr", 64'(bus.o_rptr), 64'd2);
        check("bp_valid", 64'(bus.o_tvalid), 64'd1);
        check("bp_data", 64'(bus.o_tdata), 64'h2000);
        tick();
        tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) check("bp_resume_ren", 64'(bus.o_ram_ren), 64'd1);
            check("bp_drain_valid", 64'(bus.o_tvalid), 64'd1);
            check("bp_drain_data", 64'(bus.o_tdata), 64'(32'h2000 + i));
            tick();
        end
        @(negedge clk);
        check("bp_end_valid", 64'(bus.o_tvalid), 64'd0);
        tick();

        // Reset in the middle of a stream.
        do_reset(3);
        for (int i = 0; i < 8; i++) do_write(32'h3000 + i);
        tready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            tick();
        end
        rstn = 1'b0;
        wptr = 5'd0;
        q.delete();
        pops = 5'd0;
        @(negedge clk);
        check("mrst_ren_in_reset", 64'(bus.o_ram_ren), 64'd0);
        tick();
        @(negedge clk);
        check("mrst_tvalid", 64'(bus.o_tvalid), 64'd0);
        check("mrst_rptr", 64'(bus.o_rptr), 64'd0);
        check("mrst_ren", 64'(bus.o_ram_ren), 64'd0);
        tick();
        rstn = 1'b1;
        prev_rptr = 5'd0;
        repeat (6) begin
            @(negedge clk);
            check("mrst_idle_valid", 64'(bus.o_tvalid), 64'd0);
            tick();
        end

        // Random writes and backpressure through many pointer wraps.
        do_reset(2);
        wraps = 0;
        for (int c = 0; c < 800; c++) begin
            if ((wptr - bus.o_rptr) < 5'd16 && $urandom_range(0, 9) < 6) do_write($urandom);
            tready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            tick();
        end
        tready = 1'b1;
        for (int c = 0; c < 40 && q.size() != 0; c++) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        check("rand_all_delivered", 64'(q.size()), 64'd0);
        check("rand_end_valid", 64'(bus.o_tvalid), 64'd0);
        check("rand_rptr_eq_wptr", 64'(bus.o_rptr), 64'(wptr));
        check("rand_pointer_wrapped", 64'(wraps > 0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
